// File: rtl/raw_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage RV32I pipeline: tracks destination
// registers per stage and derives bypass selects, forwarding selects and load-use stalls.
module raw_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  input  logic             mem_stall_i,
  input  logic             cnt_clr_i,
  output logic             mux_Sel_RAW_ID_rs1,
  output logic             mux_Sel_RAW_ID_rs2,
  output logic [1:0]       fwd_ex_rs1,
  output logic [1:0]       fwd_ex_rs2,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             idex_bubble_o,
  output logic             ifid_flush_o,
  output logic             loaduse_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Shadow destination state for EX, MEM and WB
  logic [1:0][REG_W-1:0] ex_rs_reg;
  logic [REG_W-1:0]      ex_rd_reg, mem_rd_reg, wb_rd_reg;
  logic                  ex_regwrite_reg, mem_regwrite_reg, wb_regwrite_reg;
  logic                  ex_memread_reg;
  logic [CNT_W-1:0]      stall_cnt_reg;

  logic [1:0][REG_W-1:0] id_rs;
  logic [1:0]            id_use;
  logic [1:0]            id_bypass;
  logic [1:0][1:0]       fwd_sel;
  logic [1:0]            ex_hit;
  logic                  loaduse;
  logic                  ex_load_bubble;

  assign id_rs  = {id_rs2_i, id_rs1_i};
  assign id_use = {id_use_rs2_i, id_use_rs1_i};

  // A stage "writes x" only for a real write to a non-zero register
  function automatic logic writes(input logic rw, input logic [REG_W-1:0] rd,
                                  input logic [REG_W-1:0] x);
    return rw && (rd != '0) && (rd == x);
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      assign id_bypass[gi] = id_valid_i & id_use[gi]
                           & writes(wb_regwrite_reg, wb_rd_reg, id_rs[gi]);
      // EX/MEM result is younger than MEM/WB, so it takes precedence
      assign fwd_sel[gi] = writes(mem_regwrite_reg, mem_rd_reg, ex_rs_reg[gi]) ? 2'b10 :
                           writes(wb_regwrite_reg,  wb_rd_reg,  ex_rs_reg[gi]) ? 2'b01 :
                                                                                 2'b00;
      assign ex_hit[gi] = id_use[gi] & writes(ex_regwrite_reg, ex_rd_reg, id_rs[gi]);
    end
  endgenerate

  assign mux_Sel_RAW_ID_rs1 = id_bypass[0];
  assign mux_Sel_RAW_ID_rs2 = id_bypass[1];
  assign fwd_ex_rs1         = fwd_sel[0];
  assign fwd_ex_rs2         = fwd_sel[1];
  assign loaduse            = id_valid_i & ex_memread_reg & (|ex_hit);
  assign loaduse_stall_o    = loaduse;
  assign stall_cnt_o        = stall_cnt_reg;

  always_comb begin
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    if (mem_stall_i) begin
      pc_en_o   = 1'b0;
      ifid_en_o = 1'b0;
    end else if (flush_i) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (loaduse) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_bubble_o = 1'b1;
    end
  end

  assign ex_load_bubble = idex_bubble_o | ~id_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs_reg        <= '0;
      ex_rd_reg        <= '0;
      ex_regwrite_reg  <= 1'b0;
      ex_memread_reg   <= 1'b0;
      mem_rd_reg       <= '0;
      mem_regwrite_reg <= 1'b0;
      wb_rd_reg        <= '0;
      wb_regwrite_reg  <= 1'b0;
    end else if (!mem_stall_i) begin
      wb_rd_reg        <= mem_rd_reg;
      wb_regwrite_reg  <= mem_regwrite_reg;
      mem_rd_reg       <= ex_rd_reg;
      mem_regwrite_reg <= ex_regwrite_reg;
      if (ex_load_bubble) begin
        ex_rs_reg       <= '0;
        ex_rd_reg       <= '0;
        ex_regwrite_reg <= 1'b0;
        ex_memread_reg  <= 1'b0;
      end else begin
        ex_rs_reg       <= id_rs;
        ex_rd_reg       <= id_rd_i;
        ex_regwrite_reg <= id_regwrite_i;
        ex_memread_reg  <= id_memread_i;
      end
    end
  end

  // Counts only stalls that actually cost a cycle; saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i) begin
      stall_cnt_reg <= '0;
    end else if (loaduse && !flush_i && !mem_stall_i && !(&stall_cnt_reg)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_raw_hazard_ctrl.sv
// Directed-vector bench for raw_hazard_ctrl; counter built 2 bits wide to reach saturation quickly.
module tb_raw_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 2;
  // {mux1, mux2, fwd1, fwd2, pc_en, ifid_en, bubble, flush, loaduse}
  localparam logic [10:0] NORM  = 11'b0_0_00_00_1_1_0_0_0;
  localparam logic [10:0] STALL = 11'b0_0_00_00_0_0_1_0_1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid_i;
  logic [REG_W-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic             id_use_rs1_i, id_use_rs2_i, id_regwrite_i, id_memread_i;
  logic             flush_i, mem_stall_i, cnt_clr_i;
  logic             mux_Sel_RAW_ID_rs1, mux_Sel_RAW_ID_rs2;
  logic [1:0]       fwd_ex_rs1, fwd_ex_rs2;
  logic             pc_en_o, ifid_en_o, idex_bubble_o, ifid_flush_o, loaduse_stall_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int vectors    = 0;
  int miscompares = 0;
  logic [10:0] obs;
  logic [10:0] exp_v;
  logic [CNT_W-1:0] exp_c;

  assign obs = {mux_Sel_RAW_ID_rs1, mux_Sel_RAW_ID_rs2, fwd_ex_rs1, fwd_ex_rs2,
                pc_en_o, ifid_en_o, idex_bubble_o, ifid_flush_o, loaduse_stall_o};

  always #5 clk = ~clk;

  raw_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .mem_stall_i(mem_stall_i), .cnt_clr_i(cnt_clr_i),
    .mux_Sel_RAW_ID_rs1(mux_Sel_RAW_ID_rs1), .mux_Sel_RAW_ID_rs2(mux_Sel_RAW_ID_rs2),
    .fwd_ex_rs1(fwd_ex_rs1), .fwd_ex_rs2(fwd_ex_rs2),
    .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .idex_bubble_o(idex_bubble_o),
    .ifid_flush_o(ifid_flush_o), .loaduse_stall_o(loaduse_stall_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                        input logic u2, input int rd, input logic rw, input logic mr);
    id_valid_i    = v;
    id_rs1_i      = rs1[REG_W-1:0];
    id_use_rs1_i  = u1;
    id_rs2_i      = rs2[REG_W-1:0];
    id_use_rs2_i  = u2;
    id_rd_i       = rd[REG_W-1:0];
    id_regwrite_i = rw;
    id_memread_i  = mr;
    #1;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; mem_stall_i = 1'b0; cnt_clr_i = 1'b0;
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      $display("reset_idle[%0d] obs=%b cnt=%0d", i, obs, stall_cnt_o);
      if (obs !== NORM || stall_cnt_o !== '0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d] obs=%b cnt=%0d expected obs=%b cnt=0", i, obs, stall_cnt_o, NORM);
      end
      tick();
    end
  endtask

  task automatic test_alu_forward();
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0);   // add x5,x1,x2
    tick();
    set_id(1'b1, 5, 1'b1, 3, 1'b1, 6, 1'b1, 1'b0);   // sub x6,x5,x3
    vectors++;
    $display("alu_no_stall obs=%b", obs);
    if (obs !== NORM) begin
      miscompares++;
      $display("FAIL alu_no_stall obs=%b expected %b", obs, NORM);
    end
    tick();
    set_id(1'b1, 5, 1'b1, 4, 1'b1, 9, 1'b1, 1'b0);   // or x9,x5,x4
    exp_v = 11'b0_0_10_00_1_1_0_0_0;
    vectors++;
    $display("alu_fwd_exmem obs=%b", obs);
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL alu_fwd_exmem obs=%b expected %b", obs, exp_v);
    end
    tick();
    set_id(1'b1, 5, 1'b1, 0, 1'b1, 10, 1'b1, 1'b0);  // and x10,x5,x0
    exp_v = 11'b1_0_01_00_1_1_0_0_0;
    vectors++;
    $display("alu_fwd_memwb_bypass obs=%b", obs);
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL alu_fwd_memwb_bypass obs=%b expected %b", obs, exp_v);
    end
    idle(4);
  endtask

  task automatic test_load_use();
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);   // lw x7,0(x1)
    tick();
    set_id(1'b1, 7, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0);   // add x8,x7,x7
    vectors++;
    $display("lu_stall obs=%b", obs);
    if (obs !== STALL) begin
      miscompares++;
      $display("FAIL lu_stall obs=%b expected %b", obs, STALL);
    end
    tick();
    vectors++;
    $display("lu_resolved obs=%b cnt=%0d", obs, stall_cnt_o);
    if (obs !== NORM || stall_cnt_o !== 2'd1) begin
      miscompares++;
      $display("FAIL lu_resolved obs=%b cnt=%0d expected obs=%b cnt=1", obs, stall_cnt_o, NORM);
    end
    tick();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    exp_v = 11'b0_0_01_01_1_1_0_0_0;
    vectors++;
    $display("lu_fwd_memwb obs=%b", obs);
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL lu_fwd_memwb obs=%b expected %b", obs, exp_v);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);   // lw x7
    tick();
    set_id(1'b1, 7, 1'b1, 1, 1'b1, 8, 1'b1, 1'b0);   // add x8,x7,x1
    tick();
    tick();
    set_id(1'b1, 7, 1'b1, 2, 1'b1, 9, 1'b1, 1'b0);   // add x9,x7,x2
    exp_v = 11'b1_0_01_00_1_1_0_0_0;
    vectors++;
    $display("b2b_second_dep obs=%b cnt=%0d", obs, stall_cnt_o);
    if (obs !== exp_v || stall_cnt_o !== 2'd2) begin
      miscompares++;
      $display("FAIL b2b_second_dep obs=%b cnt=%0d expected obs=%b cnt=2", obs, stall_cnt_o, exp_v);
    end
    idle(4);
  endtask

  task automatic test_x0();
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1);   // lw x0,0(x1)
    tick();
    set_id(1'b1, 0, 1'b1, 0, 1'b1, 11, 1'b1, 1'b0);  // add x11,x0,x0
    vectors++;
    $display("x0_no_stall obs=%b", obs);
    if (obs !== NORM) begin
      miscompares++;
      $display("FAIL x0_no_stall obs=%b expected %b", obs, NORM);
    end
    tick();
    set_id(1'b1, 0, 1'b1, 0, 1'b1, 12, 1'b1, 1'b0);
    vectors++;
    $display("x0_no_fwd obs=%b", obs);
    if (obs !== NORM) begin
      miscompares++;
      $display("FAIL x0_no_fwd obs=%b expected %b", obs, NORM);
    end
    tick();
    set_id(1'b1, 0, 1'b1, 0, 1'b1, 13, 1'b1, 1'b0);
    vectors++;
    $display("x0_no_bypass obs=%b", obs);
    if (obs !== NORM) begin
      miscompares++;
      $display("FAIL x0_no_bypass obs=%b expected %b", obs, NORM);
    end
    idle(4);
  endtask

  task automatic test_flush();
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 7, 1'b1, 3, 1'b1, 8, 1'b1, 1'b0);
    flush_i = 1'b1;
    #1;
    exp_v = 11'b0_0_00_00_1_1_1_1_1;
    vectors++;
    $display("flush_over_stall obs=%b", obs);
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL flush_over_stall obs=%b expected %b", obs, exp_v);
    end
    tick();
    flush_i = 1'b0;
    vectors++;
    $display("flush_cnt cnt=%0d", stall_cnt_o);
    if (stall_cnt_o !== 2'd2) begin
      miscompares++;
      $display("FAIL flush_cnt cnt=%0d expected 2", stall_cnt_o);
    end
    idle(4);
  endtask

  task automatic test_mem_stall();
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0);   // add x8,x3,x7
    mem_stall_i = 1'b1;
    #1;
    exp_v = 11'b0_0_00_00_0_0_0_0_1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      $display("memstall[%0d] obs=%b cnt=%0d", i, obs, stall_cnt_o);
      if (obs !== exp_v || stall_cnt_o !== 2'd2) begin
        miscompares++;
        $display("FAIL memstall[%0d] obs=%b cnt=%0d expected obs=%b cnt=2", i, obs, stall_cnt_o, exp_v);
      end
      tick();
    end
    mem_stall_i = 1'b0;
    #1;
    vectors++;
    $display("memstall_release obs=%b", obs);
    if (obs !== STALL) begin
      miscompares++;
      $display("FAIL memstall_release obs=%b expected %b", obs, STALL);
    end
    tick();
    vectors++;
    $display("memstall_resolved obs=%b cnt=%0d", obs, stall_cnt_o);
    if (obs !== NORM || stall_cnt_o !== 2'd3) begin
      miscompares++;
      $display("FAIL memstall_resolved obs=%b cnt=%0d expected obs=%b cnt=3", obs, stall_cnt_o, NORM);
    end
    tick();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    exp_v = 11'b0_0_00_01_1_1_0_0_0;
    vectors++;
    $display("memstall_fwd obs=%b", obs);
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL memstall_fwd obs=%b expected %b", obs, exp_v);
    end
    idle(4);
  endtask

  task automatic test_saturate_clear();
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0);
    tick();
    vectors++;
    $display("cnt_saturate cnt=%0d", stall_cnt_o);
    if (stall_cnt_o !== 2'd3) begin
      miscompares++;
      $display("FAIL cnt_saturate cnt=%0d expected 3", stall_cnt_o);
    end
    idle(4);
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    exp_c = '0;
    vectors++;
    $display("cnt_clear cnt=%0d", stall_cnt_o);
    if (stall_cnt_o !== exp_c) begin
      miscompares++;
      $display("FAIL cnt_clear cnt=%0d expected 0", stall_cnt_o);
    end
    idle(4);
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0);
    tick();                                          // counter now 1
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0);
    mem_stall_i = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_stall_i = 1'b0;
    #1;
    vectors++;
    $display("reset_mid_stall obs=%b cnt=%0d", obs, stall_cnt_o);
    if (obs !== NORM || stall_cnt_o !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_stall obs=%b cnt=%0d expected obs=%b cnt=0", obs, stall_cnt_o, NORM);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_back_to_back();
    test_x0();
    test_flush();
    test_mem_stall();
    test_saturate_clear();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/raw_hazard_ctrl.md
# raw_hazard_ctrl

Hazard and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It keeps a shadow copy of the destination-register state for each pipeline stage. From that state it drives the ID-stage write-back bypass selects, the EX-stage forwarding selects, load-use stalls and bubble insertion. It also counts load-use stall cycles for performance analysis.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 32, stall-counter width

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction (0 = bubble)
- id_rs1_i, id_rs2_i  in  REG_W  ID source indices
- id_use_rs1_i, id_use_rs2_i  in  1  instruction actually reads rs1/rs2
- id_rd_i  in  REG_W  ID destination index
- id_regwrite_i  in  1  ID instruction writes rd
- id_memread_i  in  1  ID instruction is a load
- flush_i  in  1  branch/jump mispredict resolved in EX; kill IF/ID contents
- mem_stall_i  in  1  data memory busy; freeze whole pipeline
- cnt_clr_i  in  1  clear stall counter
- mux_Sel_RAW_ID_rs1, mux_Sel_RAW_ID_rs2  out  1  1 = take WB data into ID operand, 0 = register-file data
- fwd_ex_rs1, fwd_ex_rs2  out  2  00 = ID/EX operand, 01 = MEM/WB result, 10 = EX/MEM result
- pc_en_o  out  1  PC register enable
- ifid_en_o  out  1  IF/ID register enable
- idex_bubble_o  out  1  load NOP into ID/EX this edge
- ifid_flush_o  out  1  load NOP into IF/ID this edge
- loaduse_stall_o  out  1  load-use hazard detected this cycle
- stall_cnt_o  out  CNT_W  load-use stall cycles since reset/clear

## Operation
- Shadow stages (registers):
  - S_EX holds rs1, rs2, rd, regwrite, memread.
  - S_MEM holds rd, regwrite, memread.
  - S_WB holds rd, regwrite.
- A stage "writes x" when its regwrite=1, rd≠0 and rd==x. Register x0 never matches.
- ID bypass: mux_Sel_RAW_ID_rsN = id_valid_i & id_use_rsN_i & S_WB writes id_rsN_i. Combinational.
- EX forwarding: fwd_ex_rsN = 10 if S_MEM writes S_EX.rsN; else 01 if S_WB writes S_EX.rsN; else 00. EX/MEM wins over MEM/WB. Combinational.
- Load-use: loaduse_stall_o = id_valid_i & S_EX.memread & ((id_use_rs1_i & S_EX writes id_rs1_i) | (id_use_rs2_i & S_EX writes id_rs2_i)).
- Control priority, highest first:
  1. mem_stall_i=1: pc_en_o=0, ifid_en_o=0, idex_bubble_o=0, ifid_flush_o=0. All shadow registers hold. Counter holds.
  2. flush_i=1: pc_en_o=1, ifid_en_o=1, ifid_flush_o=1, idex_bubble_o=1. The load-use stall is overridden, but loaduse_stall_o still reports the raw condition.
  3. loaduse_stall_o=1: pc_en_o=0, ifid_en_o=0, idex_bubble_o=1.
  4. Otherwise: pc_en_o=1, ifid_en_o=1, bubbles 0.
- Shadow advance on each edge when not frozen:
  - S_WB ← S_MEM.
  - S_MEM ← S_EX.
  - S_EX ← bubble (regwrite=0, memread=0, rd=0, rs=0) if idex_bubble_o or !id_valid_i; otherwise the ID fields.
- Stall counter:
  - Increments when loaduse_stall_o & !flush_i & !mem_stall_i.
  - Saturates at all-ones.
  - cnt_clr_i forces 0 and has priority over increment.

## Timing
- Reset (rst high at edge):
  - All shadow fields go to 0, so every stage is a bubble.
  - stall_cnt_o=0.
  - Outputs settle the following cycle to: mux_Sel=0, fwd=00, loaduse_stall_o=0, pc_en_o=1, ifid_en_o=1, bubble/flush=0. This holds while inputs are idle or x0.
- A rst assertion mid-stall takes effect at the next edge and overrides all other inputs, including mem_stall_i.
- All selects and enables are combinational from registered state plus ID inputs, with zero-cycle latency. The datapath samples them at the same edge.
- Load-use penalty is exactly one cycle. After the bubble, the load sits in S_MEM, S_EX holds the bubble, and the hazard clears. The dependent instruction then enters EX two cycles after the load and takes fwd 01.
- Back-to-back dependents on one load each resolve as above. The second dependent sees the load in S_WB and uses the ID bypass.
- If mem_stall_i is asserted during a load-use stall, the stall persists, unchanged, until mem_stall_i drops. Counter does not increment while frozen.

## Test plan
- Reset then idle NOPs (id_valid_i=0): all outputs at reset values for 10 cycles; stall_cnt_o=0.
- `add x5,x1,x2` followed by `sub x6,x5,x3`: second instruction in EX gets fwd_ex_rs1=10. A third instruction reading x5, two slots later, gets fwd 01. A fourth, three slots later, gets mux_Sel_RAW_ID_rs1=1.
- `lw x7,0(x1)` followed by `add x8,x7,x7`:
  - One cycle with loaduse_stall_o=1, pc_en_o=0, ifid_en_o=0, idex_bubble_o=1.
  - The add then gets fwd_ex_rs1=fwd_ex_rs2=01.
  - stall_cnt_o=1.
- Writes and reads of x0 (`addi x0,...` then a use of x0): no forwarding, no stall, all selects 0.
- Load-use hazard with flush_i=1 in the same cycle: ifid_flush_o=1, idex_bubble_o=1, pc_en_o=1, counter unchanged. Repeat with mem_stall_i=1 for 3 cycles mid-stall: enables stay 0, shadow state unchanged, stall resolves once mem_stall_i=0.
- Preload the counter to all-ones minus 1 via repeated stalls, or by forcing a small CNT_W=2: it saturates at 3. cnt_clr_i together with a stall yields 0.
